multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_encode_def_pkg.sv | 53 +++++
 rtl/multicycle_ctrl_op_classify.sv | 34 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// instruction classes and the default memory timeout.
package ctrl_encode_def;

    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // rt_field values that make OP_REGIMM a legal branch
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

endpackage

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational opcode decoder: maps op/rt_field to an instruction class
// and a legality flag.
module op_classify
    import ctrl_encode_def::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rt_field,
    output op_class_t  op_class,
    output logic       legal
);

    // Classify the opcode; anything not listed is illegal.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        op_class = CLS_ILLEGAL;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:          op_class = CLS_ALU;
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:         op_class = CLS_LOAD;
            OP_SW:                                       op_class = CLS_STORE;
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:            op_class = CLS_BRANCH;
            OP_REGIMM: begin
                if (rt_field == RT_BLTZ || rt_field == RT_BGEZ)
                    op_class = CLS_BRANCH;
            end
            OP_J:                                        op_class = CLS_JUMP;
            OP_JAL:                                      op_class = CLS_JAL;
            default:                                     op_class = CLS_ILLEGAL;
        endcase
    end

    assign legal = (op_class != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory
// handshake timeout. Optional feature macro PERF_CNT_EN adds cycle_cnt and
// instr_cnt performance counters.
module multicycle_ctrl
    import ctrl_encode_def::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [4:0] rt_field,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                 state_q, state_d;
    op_class_t              class_q, class_d;
    op_class_t              dec_class;
    logic                   dec_legal;
    logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
    logic                   run;
    logic                   timeout;

    op_classify u_op_classify (
        .op       (op),
        .rt_field (rt_field),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign timeout = (wait_q == TIMEOUT_CNT);
    assign state   = state_q;

    // State, latched instruction class, wait counter and the run flag that
    // keeps all outputs quiet until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_FETCH;
            class_q <= CLS_ILLEGAL;
            wait_q  <= '0;
            run     <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            run     <= 1'b1;
        end
    end

    // Next state and control outputs; the wait counter clears whenever the
    // FSM is not stalled in FETCH or MEM.
    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        wait_d        = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        bus_err       = 1'b0;

        if (run) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        mem_req = 1'b0;
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    class_d = dec_class;
                    if (dec_legal) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        CLS_BRANCH: begin
                            pc_write_cond = 1'b1;
                            instr_done    = 1'b1;
                            state_d       = S_FETCH;
                        end
                        CLS_JUMP: begin
                            pc_write   = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        CLS_JAL: begin
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        CLS_LOAD, CLS_STORE: state_d = S_MEM;
                        CLS_ALU:             state_d = S_WB;
                        default:             state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (class_q == CLS_STORE);
                    if (mem_ready) begin
                        if (class_q == CLS_STORE) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (timeout) begin
                        mem_req = 1'b0;
                        mem_we  = 1'b0;
                        iord    = 1'b0;
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter, both wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-cycle vector table plus
// hand-written sequences for timeouts and mid-instruction reset.
module tb_multicycle_ctrl;

    // Output vector order: mem_req mem_we iord ir_write pc_write
    // pc_write_cond reg_write instr_done illegal bus_err
    localparam logic [9:0] NONE    = 10'b0000000000;
    localparam logic [9:0] FW      = 10'b1000000000;
    localparam logic [9:0] FR      = 10'b1001100000;
    localparam logic [9:0] ILL     = 10'b0000000110;
    localparam logic [9:0] BR      = 10'b0000010100;
    localparam logic [9:0] JP      = 10'b0000100100;
    localparam logic [9:0] JL      = 10'b0000101100;
    localparam logic [9:0] WB      = 10'b0000001100;
    localparam logic [9:0] MLD     = 10'b1010000000;
    localparam logic [9:0] MST     = 10'b1110000000;
    localparam logic [9:0] MST_END = 10'b1110000100;
    localparam logic [9:0] BERR    = 10'b0000000001;

    localparam logic [5:0] C_R      = 6'b000000;
    localparam logic [5:0] C_REGIMM = 6'b000001;
    localparam logic [5:0] C_J      = 6'b000010;
    localparam logic [5:0] C_JAL    = 6'b000011;
    localparam logic [5:0] C_BEQ    = 6'b000100;
    localparam logic [5:0] C_BNE    = 6'b000101;
    localparam logic [5:0] C_ADDI   = 6'b001000;
    localparam logic [5:0] C_LUI    = 6'b001111;
    localparam logic [5:0] C_LB     = 6'b100000;
    localparam logic [5:0] C_LW     = 6'b100011;
    localparam logic [5:0] C_SW     = 6'b101011;
    localparam logic [5:0] C_BAD    = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [4:0] rt_field = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic       reg_write, instr_done, illegal, bus_err;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    logic [9:0] act_outs;
    assign act_outs = {mem_req, mem_we, iord, ir_write, pc_write,
                       pc_write_cond, reg_write, instr_done, illegal, bus_err};

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .rt_field      (rt_field),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .state         (state),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .bus_err       (bus_err)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rt;
        logic       rdy;
        logic [2:0] st;
        logic [9:0] outs;
    } vec_t;

    typedef struct {
        string       tag;
        logic [12:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [4:0] r, input logic rdy,
                       input logic [2:0] st, input logic [9:0] outs);
        vec_t v;
        v.op = o; v.rt = r; v.rdy = rdy; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive after the edge, queue the expectation, compare
    // {state, outputs} at the falling edge.
    task automatic step(input string tag, input logic [5:0] o, input logic [4:0] r,
                        input logic rdy, input logic [2:0] st, input logic [9:0] outs);
        sb_t e;
        @(posedge clk);
        #1;
        op = o; rt_field = r; mem_ready = rdy;
        e.tag = tag;
        e.exp = {st, outs};
        sb_q.push_back(e);
        if (outs[2]) exp_done++;
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, {19'd0, state, act_outs}, {19'd0, e.exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // addi, mem_ready high throughout (also ignored in DECODE/EXEC/WB)
        add(C_ADDI, 5'd0, 1'b1, 3'd0, FR);
        add(C_ADDI, 5'd0, 1'b1, 3'd1, NONE);
        add(C_ADDI, 5'd0, 1'b1, 3'd2, NONE);
        add(C_ADDI, 5'd0, 1'b1, 3'd4, WB);
        // beq then jal
        add(C_BEQ, 5'd0, 1'b1, 3'd0, FR);
        add(C_BEQ, 5'd0, 1'b1, 3'd1, NONE);
        add(C_BEQ, 5'd0, 1'b1, 3'd2, BR);
        add(C_JAL, 5'd0, 1'b1, 3'd0, FR);
        add(C_JAL, 5'd0, 1'b1, 3'd1, NONE);
        add(C_JAL, 5'd0, 1'b1, 3'd2, JL);
        // j after a two-cycle fetch stall
        add(C_J, 5'd0, 1'b0, 3'd0, FW);
        add(C_J, 5'd0, 1'b0, 3'd0, FW);
        add(C_J, 5'd0, 1'b1, 3'd0, FR);
        add(C_J, 5'd0, 1'b0, 3'd1, NONE);
        add(C_J, 5'd0, 1'b0, 3'd2, JP);
        // bltz, bgez
        add(C_REGIMM, 5'd0, 1'b1, 3'd0, FR);
        add(C_REGIMM, 5'd0, 1'b1, 3'd1, NONE);
        add(C_REGIMM, 5'd0, 1'b1, 3'd2, BR);
        add(C_REGIMM, 5'd1, 1'b1, 3'd0, FR);
        add(C_REGIMM, 5'd1, 1'b1, 3'd1, NONE);
        add(C_REGIMM, 5'd1, 1'b1, 3'd2, BR);
        // illegal opcodes
        add(C_BAD, 5'd0, 1'b1, 3'd0, FR);
        add(C_BAD, 5'd0, 1'b1, 3'd1, ILL);
        add(C_REGIMM, 5'd2, 1'b1, 3'd0, FR);
        add(C_REGIMM, 5'd2, 1'b1, 3'd1, ILL);
        // lw with three stalled MEM cycles: 8 cycles total
        add(C_LW, 5'd0, 1'b1, 3'd0, FR);
        add(C_LW, 5'd0, 1'b0, 3'd1, NONE);
        add(C_LW, 5'd0, 1'b0, 3'd2, NONE);
        add(C_LW, 5'd0, 1'b0, 3'd3, MLD);
        add(C_LW, 5'd0, 1'b0, 3'd3, MLD);
        add(C_LW, 5'd0, 1'b0, 3'd3, MLD);
        add(C_LW, 5'd0, 1'b1, 3'd3, MLD);
        add(C_LW, 5'd0, 1'b0, 3'd4, WB);
        // sw with immediate mem_ready: 4 cycles
        add(C_SW, 5'd0, 1'b1, 3'd0, FR);
        add(C_SW, 5'd0, 1'b1, 3'd1, NONE);
        add(C_SW, 5'd0, 1'b1, 3'd2, NONE);
        add(C_SW, 5'd0, 1'b1, 3'd3, MST_END);
        // R-type, lui, bne, lb
        add(C_R, 5'd0, 1'b1, 3'd0, FR);
        add(C_R, 5'd0, 1'b1, 3'd1, NONE);
        add(C_R, 5'd0, 1'b1, 3'd2, NONE);
        add(C_R, 5'd0, 1'b1, 3'd4, WB);
        add(C_LUI, 5'd0, 1'b1, 3'd0, FR);
        add(C_LUI, 5'd0, 1'b1, 3'd1, NONE);
        add(C_LUI, 5'd0, 1'b1, 3'd2, NONE);
        add(C_LUI, 5'd0, 1'b1, 3'd4, WB);
        add(C_BNE, 5'd0, 1'b1, 3'd0, FR);
        add(C_BNE, 5'd0, 1'b1, 3'd1, NONE);
        add(C_BNE, 5'd0, 1'b1, 3'd2, BR);
        add(C_LB, 5'd0, 1'b1, 3'd0, FR);
        add(C_LB, 5'd0, 1'b1, 3'd1, NONE);
        add(C_LB, 5'd0, 1'b1, 3'd2, NONE);
        add(C_LB, 5'd0, 1'b1, 3'd3, MLD);
        add(C_LB, 5'd0, 1'b0, 3'd4, WB);
        // fetch stall at wait count 0; the timeout sequence continues from here
        add(C_ADDI, 5'd0, 1'b0, 3'd0, FW);

        // Reset state: everything low while rst is high
        #2;
        check("reset_outputs", {19'd0, state, act_outs}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pre_edge_mem_req", {31'd0, mem_req}, 32'd0);
`ifdef PERF_CNT_EN
        check("cycle_cnt_after_reset", cycle_cnt, 32'd0);
        check("instr_cnt_after_reset", instr_cnt, 32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("table[%0d]", i), vecs[i].op, vecs[i].rt, vecs[i].rdy,
                 vecs[i].st, vecs[i].outs);

`ifdef PERF_CNT_EN
        check("instr_cnt_after_table", instr_cnt, exp_done);
`endif

        // Fetch timeout: stall counts 1..14 hold mem_req, count 15 flags bus_err
        for (int i = 1; i < 15; i++)
            step($sformatf("fetch_stall[%0d]", i), C_ADDI, 5'd0, 1'b0, 3'd0, FW);
        step("fetch_timeout", C_ADDI, 5'd0, 1'b0, 3'd0, BERR);
        step("fetch_after_timeout", C_ADDI, 5'd0, 1'b0, 3'd0, FW);

        // mem_ready arriving exactly at count 15 wins over the timeout
        for (int i = 1; i < 15; i++)
            step($sformatf("fetch_restall[%0d]", i), C_ADDI, 5'd0, 1'b0, 3'd0, FW);
        step("fetch_ready_at_limit", C_ADDI, 5'd0, 1'b1, 3'd0, FR);
        step("limit_decode", C_ADDI, 5'd0, 1'b0, 3'd1, NONE);
        step("limit_exec", C_ADDI, 5'd0, 1'b0, 3'd2, NONE);
        step("limit_wb", C_ADDI, 5'd0, 1'b0, 3'd4, WB);

        // MEM timeout on a load: no write-back, straight back to FETCH
        step("memto_fetch", C_LW, 5'd0, 1'b1, 3'd0, FR);
        step("memto_decode", C_LW, 5'd0, 1'b0, 3'd1, NONE);
        step("memto_exec", C_LW, 5'd0, 1'b0, 3'd2, NONE);
        for (int i = 0; i < 15; i++)
            step($sformatf("mem_stall[%0d]", i), C_LW, 5'd0, 1'b0, 3'd3, MLD);
        step("mem_timeout", C_LW, 5'd0, 1'b0, 3'd3, BERR);

        // Reset in the middle of a store's MEM phase
        step("rst_sw_fetch", C_SW, 5'd0, 1'b1, 3'd0, FR);
        step("rst_sw_decode", C_SW, 5'd0, 1'b0, 3'd1, NONE);
        step("rst_sw_exec", C_SW, 5'd0, 1'b0, 3'd2, NONE);
        step("rst_sw_mem0", C_SW, 5'd0, 1'b0, 3'd3, MST);
        step("rst_sw_mem1", C_SW, 5'd0, 1'b0, 3'd3, MST);
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid_mem", {19'd0, state, act_outs}, 32'd0);
`ifdef PERF_CNT_EN
        check("cycle_cnt_mid_reset", cycle_cnt, 32'd0);
        check("instr_cnt_mid_reset", instr_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        op = C_ADDI;
        mem_ready = 1'b1;
        #1;
        check("pre_edge_mem_req_2", {31'd0, mem_req}, 32'd0);
        step("post_reset_fetch", C_ADDI, 5'd0, 1'b1, 3'd0, FR);
        step("post_reset_decode", C_ADDI, 5'd0, 1'b1, 3'd1, NONE);
        step("post_reset_exec", C_ADDI, 5'd0, 1'b1, 3'd2, NONE);
        step("post_reset_wb", C_ADDI, 5'd0, 1'b1, 3'd4, WB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
